// File: rtl/multicycle_control_fsm.sv
// Control unit for the multicycle RV32I core: main state machine, ALU decoder and
// immediate-select decoder driving the datapath muxes and all write enables.
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         Op,
   input  logic [2:0]         Funct3,
   input  logic               Funct7b5,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic               Illegal,
   output logic [STATE_W-1:0] State
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECR    = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_EXECI    = STATE_W'(8),
      S_JAL      = STATE_W'(9),
      S_BEQ      = STATE_W'(10),
      S_ILLEGAL  = STATE_W'(11)
   } state_t;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   state_t state;
   ctrl_t  ctrl;

   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.pc_update  = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b10;
         end
         S_ALUWB:    c.reg_write = 1'b1;
         S_EXECI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b10;
         end
         S_JAL: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_update = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b01;
            c.branch    = 1'b1;
         end
         S_ILLEGAL:  c.illegal = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] op);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH: n = S_DECODE;
         S_DECODE: begin
            case (op)
               7'b0000011, 7'b0100011: n = S_MEMADR;
               7'b0110011:             n = S_EXECR;
               7'b0010011:             n = S_EXECI;
               7'b1101111:             n = S_JAL;
               7'b1100011:             n = S_BEQ;
               default:                n = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  n = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: n = S_MEMWB;
         S_EXECR:   n = S_ALUWB;
         S_EXECI:   n = S_ALUWB;
         S_JAL:     n = S_ALUWB;
         S_ILLEGAL: n = S_ILLEGAL;
         default:   n = S_FETCH;
      endcase
      return n;
   endfunction

   // Control bits are registered from the next state so they always match the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         ctrl  <= decode_state(S_FETCH);
      end else begin
         state <= next_state(state, Op);
         ctrl  <= decode_state(next_state(state, Op));
      end
   end

   // Enables are gated by rst_n so nothing writes during reset, yet fetch is live right after release.
   assign PCWrite   = rst_n & (ctrl.pc_update | (ctrl.branch & Zero));
   assign MemWrite  = rst_n & ctrl.mem_write;
   assign IRWrite   = rst_n & ctrl.ir_write;
   assign RegWrite  = rst_n & ctrl.reg_write;
   assign AdrSrc    = ctrl.adr_src;
   assign ResultSrc = ctrl.result_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign Illegal   = ctrl.illegal;
   assign State     = state;

   always_comb begin
      ALUControl = 3'b000;
      case (ctrl.alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (Funct3)
               3'b000:  ALUControl = (Op[5] & Funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (Op)
         7'b0100011: ImmSrc = 2'b01;
         7'b1100011: ImmSrc = 2'b10;
         7'b1101111: ImmSrc = 2'b11;
         default:    ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// its state sequence and checks every control output against hand-derived values.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] Op = 7'b0110011;
   logic [2:0] Funct3 = 3'b000;
   logic       Funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
   );

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                                input logic z);
      Op = op;
      Funct3 = f3;
      Funct7b5 = f7b5;
      Zero = z;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One call checks every state-driven output of the current cycle.
   task automatic checkCycle(input string tag, input int st, input logic pcw, input logic adr,
                             input logic memw, input logic irw, input logic regw,
                             input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                             input logic [2:0] aluc, input logic ill);
      checkOutput({tag, ".State"}, 32'(State), 32'(st));
      checkOutput({tag, ".PCWrite"}, 32'(PCWrite), 32'(pcw));
      checkOutput({tag, ".AdrSrc"}, 32'(AdrSrc), 32'(adr));
      checkOutput({tag, ".MemWrite"}, 32'(MemWrite), 32'(memw));
      checkOutput({tag, ".IRWrite"}, 32'(IRWrite), 32'(irw));
      checkOutput({tag, ".RegWrite"}, 32'(RegWrite), 32'(regw));
      checkOutput({tag, ".ResultSrc"}, 32'(ResultSrc), 32'(rs));
      checkOutput({tag, ".ALUSrcA"}, 32'(ALUSrcA), 32'(asa));
      checkOutput({tag, ".ALUSrcB"}, 32'(ALUSrcB), 32'(asb));
      checkOutput({tag, ".ALUControl"}, 32'(ALUControl), 32'(aluc));
      checkOutput({tag, ".Illegal"}, 32'(Illegal), 32'(ill));
   endtask

   task automatic expectReset(input string tag);
      checkCycle(tag, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endtask

   task automatic expectFetch(input string tag);
      checkCycle(tag, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endtask

   task automatic expectDecode(input string tag);
      checkCycle(tag, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
   endtask

   task automatic expectAluWb(input string tag);
      checkCycle(tag, 7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endtask

   // R/I-type vectors: opcode, funct3, funct7b5, expected ALUControl in the execute state.
   logic [6:0] alu_op_v [6] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011};
   logic [2:0] alu_f3_v [6] = '{3'b000, 3'b111, 3'b000, 3'b010, 3'b110, 3'b001};
   logic       alu_f7_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [2:0] alu_exp_v[6] = '{3'b001, 3'b010, 3'b000, 3'b101, 3'b011, 3'b000};

   initial begin
      $display("[TB] reset hold");
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expectReset("reset_hold");
      end
      rst_n = 1'b1;
      #1 expectFetch("reset_release");

      $display("[TB] R-type add straight out of reset");
      @(negedge clk); expectDecode("radd_decode");
      @(negedge clk); checkCycle("radd_exec", 6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 0);
      @(negedge clk); expectAluWb("radd_wb");
      @(negedge clk); expectFetch("radd_fetch");

      $display("[TB] lw");
      applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
      #1 checkOutput("lw.ImmSrc", 32'(ImmSrc), 32'd0);
      @(negedge clk); expectDecode("lw_decode");
      @(negedge clk); checkCycle("lw_memadr", 2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      @(negedge clk); checkCycle("lw_memread", 3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      @(negedge clk); checkCycle("lw_memwb", 4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
      @(negedge clk); expectFetch("lw_fetch");

      $display("[TB] sw");
      applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
      #1 checkOutput("sw.ImmSrc", 32'(ImmSrc), 32'd1);
      @(negedge clk); expectDecode("sw_decode");
      @(negedge clk); checkCycle("sw_memadr", 2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      @(negedge clk); checkCycle("sw_memwrite", 5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      @(negedge clk); expectFetch("sw_fetch");

      $display("[TB] ALU decoder vectors");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(alu_op_v[k], alu_f3_v[k], alu_f7_v[k], 1'b0);
         @(negedge clk); expectDecode($sformatf("alu%0d_decode", k));
         @(negedge clk);
         if (alu_op_v[k] == 7'b0110011)
            checkCycle($sformatf("alu%0d_execr", k), 6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
                       alu_exp_v[k], 0);
         else
            checkCycle($sformatf("alu%0d_execi", k), 8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
                       alu_exp_v[k], 0);
         @(negedge clk); expectAluWb($sformatf("alu%0d_wb", k));
         @(negedge clk); expectFetch($sformatf("alu%0d_fetch", k));
      end

      $display("[TB] beq taken and not taken");
      applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
      #1 checkOutput("beq.ImmSrc", 32'(ImmSrc), 32'd2);
      @(negedge clk); expectDecode("beqt_decode");
      @(negedge clk); checkCycle("beqt_beq", 10, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
      @(negedge clk); expectFetch("beqt_fetch");
      applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
      @(negedge clk); expectDecode("beqn_decode");
      @(negedge clk); checkCycle("beqn_beq", 10, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
      @(negedge clk); expectFetch("beqn_fetch");

      $display("[TB] jal");
      applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
      #1 checkOutput("jal.ImmSrc", 32'(ImmSrc), 32'd3);
      @(negedge clk); expectDecode("jal_decode");
      @(negedge clk); checkCycle("jal_jal", 9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
      @(negedge clk); expectAluWb("jal_wb");
      @(negedge clk); expectFetch("jal_fetch");

      $display("[TB] reset during lw");
      applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
      @(negedge clk); expectDecode("lwabort_decode");
      @(negedge clk); checkCycle("lwabort_memadr", 2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      @(negedge clk); checkCycle("lwabort_memread", 3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      rst_n = 1'b0;
      #1 expectReset("lwabort_reset");
      @(negedge clk); expectReset("lwabort_hold");
      applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1 expectFetch("lwabort_release");

      $display("[TB] illegal opcode trap");
      checkOutput("ill.ImmSrc", 32'(ImmSrc), 32'd0);
      @(negedge clk); expectDecode("ill_decode");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkCycle($sformatf("ill_trap%0d", c), 11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
      end
      rst_n = 1'b0;
      #1 expectReset("ill_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit for the multicycle RV32I core: main state machine, ALU decoder and immediate-select decoder.
- Drives the select inputs of the core's 3-input datapath muxes (ResultSrc, ALUSrcA, ALUSrcB) and all register and memory write enables.
- Sits directly upstream of those muxes and of the ALU.
- Supports lw, sw, R-type, I-type ALU, jal and beq. Any other opcode traps to an error state.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  7  instruction bits [6:0]
- Funct3  in  3  instruction bits [14:12]
- Funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  high while in the trap state
- State  out  STATE_W  current state, for debug

Behaviour:
- Moore FSM. All outputs except PCWrite and ALUControl are a function of state only. ImmSrc is a function of Op only.
- Select outputs never take the value 11. A mux treats 11 as 10, but any 11 is a bench failure.
- Asynchronous reset: state = FETCH (0).
  - While rst_n = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Selects show FETCH values.
  - The first fetch enable is in the first cycle after rst_n rises.
  - Reset mid-instruction aborts it. No write enable is asserted in the reset cycle.
- State encodings, outputs and next state. Outputs not listed are 0; ALUOp defaults to 00.
  - FETCH(0): AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, PCUpdate 1. Next DECODE.
  - DECODE(1): ALUSrcA 01, ALUSrcB 01. Next by Op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - else -> ILLEGAL
  - MEMADR(2): ALUSrcA 10, ALUSrcB 01. Next MEMREAD if Op[5] = 0, else MEMWRITE.
  - MEMREAD(3): ResultSrc 00, AdrSrc 1. Next MEMWB.
  - MEMWB(4): ResultSrc 01, RegWrite 1. Next FETCH.
  - MEMWRITE(5): ResultSrc 00, AdrSrc 1, MemWrite 1. Next FETCH.
  - EXECR(6): ALUSrcA 10, ALUSrcB 00, ALUOp 10. Next ALUWB.
  - ALUWB(7): ResultSrc 00, RegWrite 1. Next FETCH.
  - EXECI(8): ALUSrcA 10, ALUSrcB 01, ALUOp 10. Next ALUWB.
  - JAL(9): ALUSrcA 01, ALUSrcB 10, ResultSrc 00, PCUpdate 1. Next ALUWB.
  - BEQ(10): ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1. Next FETCH.
  - ILLEGAL(11): Illegal 1, all enables 0. Stays until reset.
  - Encodings 12–15 go to FETCH on the next clock, with all enables 0.
- PCWrite = PCUpdate | (Branch & Zero). Zero is sampled combinationally in BEQ only.
- Instruction latency:
  - lw = 5 cycles
  - sw, R, I, jal = 4 cycles
  - beq = 3 cycles
- ALU decoder (combinational):
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, decoded on Funct3:
    - 000 -> sub if Op[5] & Funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- ImmSrc by Op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with Op = 0110011 -> State = 0, all enables 0. In the first cycle after release, IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10.
- lw: Op = 0000011 -> state sequence 0,1,2,3,4,0. RegWrite = 1 only in state 4, with ResultSrc = 01. AdrSrc = 1 in state 3. ImmSrc = 00.
- sw then R-type sub: Op = 0100011 -> sequence 0,1,2,5,0 with MemWrite = 1 only in state 5. Then Op = 0110011, Funct3 = 000, Funct7b5 = 1 -> ALUControl = 001 in state 6, RegWrite = 1 in state 7.
- beq: Op = 1100011, Zero = 1 in state 10 -> PCWrite = 1 and ALUControl = 001. Repeat with Zero = 0 -> PCWrite = 0. Both return to state 0 after 3 cycles.
- jal: Op = 1101111 -> sequence 0,1,9,7,0. PCWrite = 1 in state 9. ALUSrcA = 01, ALUSrcB = 10. ImmSrc = 11.
- Illegal and mid-instruction reset: Op = 1111111 -> state 11, Illegal = 1, held for 10 cycles with no enables. Separately, assert rst_n = 0 in state 3 of a lw -> State = 0 immediately, and RegWrite is never asserted.
